seg_scan_multi: RTL and testbench
=================================

// Module: seg_scan_multi
// PURPOSE
//  Parametrised multiplexed 7-segment scan driver for N_DIG common-select digits.
//  Scans packed BCD digits one slot at a time and adds per-digit decimal point,
//  per-digit blink, leading-zero blanking, an anti-ghost guard gap and a run enable.
//  Sits between the clock/counter logic (hour/min/sec BCD) and the board seg/sel pins.
// PARAMETERS
//  N_DIG       6            number of digits, 1..8
//  SCAN_CYC    100_000      clk cycles per digit slot (2 ms @ 50 MHz), >=2
//  BLANK_CYC   1_000        guard cycles at slot start with all selects off, < SCAN_CYC
//  BLINK_CYC   25_000_000   blink half-period in clk cycles (0.5 s @ 50 MHz)
//  SEL_ACT_LOW 1            1: seg_sel active-low; 0: active-high
//  SEG_ACT_LOW 1            1: seg_ment/seg_dp active-low; 0: active-high
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous reset, active-high
//  enable     in   1          1 = scan running; 0 = display dark
//  digits     in   4*N_DIG    packed BCD; digit i = digits[4i+3:4i]; digit 0 scanned first
//  dp_en      in   N_DIG      decimal point on for digit i
//  blink_en   in   N_DIG      digit i blinks
//  lz_blank   in   1          suppress leading zeros
//  seg_sel    out  N_DIG      digit select, one-hot (polarity per SEL_ACT_LOW)
//  seg_ment   out  7          segments, bit6=a .. bit0=g
//  seg_dp     out  1          decimal point segment
//  slot_idx   out  3          index of the digit currently being scanned
//  frame_tick out  1          1-cycle pulse when the last slot of a frame ends
// BEHAVIOUR
//  Reset: all selects inactive, seg_ment/seg_dp off, slot_idx=0, frame_tick=0,
//   slot counter=0, blink counter=0, blink phase=0, state OFF.
//  FSM: OFF -> GUARD when enable=1; GUARD -> DRIVE after BLANK_CYC cycles;
//   DRIVE -> GUARD of the next digit at slot end (slot counter = SCAN_CYC-1).
//   Any state -> OFF on the cycle enable=0.
//  OFF: slot counter and slot_idx held at 0; outputs dark. Re-enable always starts at digit 0.
//  Slot: counter 0..SCAN_CYC-1. slot_idx wraps N_DIG-1 -> 0.
//   frame_tick is asserted on the wrap cycle.
//  Snapshot: digits, dp_en, blink_en and lz_blank are sampled on the first cycle of each slot.
//   Mid-slot input changes take effect at the next slot only.
//  Outputs are registered. seg_sel, seg_ment and seg_dp change together, 1 clk after the FSM/counter event.
//  GUARD: all selects inactive; seg_ment/seg_dp off.
//  DRIVE: only select slot_idx active; segments show the decoded snapshot digit.
//  Decode (logical, 1 = lit): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B.
//   Codes A-F = blank (00).
//  Leading-zero blanking: with lz_blank=1, digit i (i>=1) is blank when it and every higher digit are 0.
//   Digit 0 is never lz-blanked. dp stays governed by dp_en.
//  Blink: free-running counter toggles blink phase every BLINK_CYC cycles; it runs even when enable=0.
//   While phase=1, digits with blink_en set show segments and dp off; their select is still driven.
//  Polarity: SEG_ACT_LOW=1 inverts seg_ment/seg_dp (e.g. 0 -> 7'h01, 8 -> 7'h00, blank -> 7'h7F).
//   SEL_ACT_LOW=1 inverts seg_sel.
//  rst mid-slot: takes priority over everything; next cycle equals the reset state.
// TESTING (N_DIG=4, SCAN_CYC=8, BLANK_CYC=2, BLINK_CYC=64, both polarities active-low)
//  1 Reset: rst=1 for 3 clk with enable=1 -> seg_sel=4'hF, seg_ment=7'h7F, seg_dp=1,
//    slot_idx=0, frame_tick=0 on every cycle.
//  2 Scan: digits=16'h1234, enable=1 -> per slot: 2 cycles sel=F, then 6 cycles of
//    sel=E/seg=4C, D/06, B/12, 7/4F in turn; frame_tick pulses every 32 cycles.
//  3 LZ blank: digits=16'h0050, lz_blank=1 -> digits 3,2 = 7F, digit1 = 24, digit0 = 01.
//    digits=16'h0000 -> only digit0 lit (01). Code 4'hA on any digit -> 7F.
//  4 Blink/dp: blink_en=4'b0001, dp_en=4'b0001 -> digit0 seg and dp lit for 64 cycles,
//    dark for the next 64, sel E still asserted in its slot.
//  5 Enable/snapshot: change digits mid-slot -> current slot unchanged, next slot shows new value;
//    drop enable mid-slot 2 -> dark next cycle; re-raise -> GUARD at digit 0, slot counter 0.

Source files
------------

// File: rtl/seg_scan_multi_if.sv
// Scan driver interface: display content in, board-pin drive and scan status out.
// The master modport drives display content; the slave modport is the driver.
interface seg_scan_multi_if #(
    parameter int N_DIG = 6
);
    logic                 enable;
    logic [4*N_DIG-1:0]   digits;
    logic [N_DIG-1:0]     dp_en;
    logic [N_DIG-1:0]     blink_en;
    logic                 lz_blank;
    logic [N_DIG-1:0]     seg_sel;
    logic [6:0]           seg_ment;
    logic                 seg_dp;
    logic [2:0]           slot_idx;
    logic                 frame_tick;

    modport master (
        output enable, digits, dp_en, blink_en, lz_blank,
        input  seg_sel, seg_ment, seg_dp, slot_idx, frame_tick
    );

    modport slave (
        input  enable, digits, dp_en, blink_en, lz_blank,
        output seg_sel, seg_ment, seg_dp, slot_idx, frame_tick
    );
endinterface

// File: rtl/seg_scan_multi.sv
// Multiplexed 7-segment scan driver: guard gap, per-digit dp/blink,
// leading-zero blanking and a run enable, all with registered pin outputs.
module seg_scan_multi #(
    parameter int N_DIG       = 6,
    parameter int SCAN_CYC    = 100_000,
    parameter int BLANK_CYC   = 1_000,
    parameter int BLINK_CYC   = 25_000_000,
    parameter bit SEL_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input logic           clk,
    input logic           rst,
    seg_scan_multi_if.slave io
);
    localparam int CW  = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int BW  = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam int BL1 = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

    localparam logic [N_DIG-1:0] SEL_OFF = SEL_ACT_LOW ? '1 : '0;
    localparam logic [6:0]       SEG_OFF = SEG_ACT_LOW ? '1 : '0;
    localparam logic             DP_OFF  = SEG_ACT_LOW;

    typedef enum logic [1:0] {
        S_OFF,
        S_GUARD,
        S_DRIVE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           slot_q, slot_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic                 bph_q, bph_d;
    logic [4*N_DIG-1:0]   sdig_q, sdig_d;
    logic [N_DIG-1:0]     sdp_q, sdp_d;
    logic [N_DIG-1:0]     sblk_q, sblk_d;
    logic                 slz_q, slz_d;
    logic [N_DIG-1:0]     sel_q, sel_d;
    logic [6:0]           ment_q, ment_d;
    logic                 dp_q, dp_d;
    logic                 tick_q, tick_d;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    state_t      start_st;
    logic        slot_start;
    logic        slot_last;
    logic [31:0] dig32;
    logic [7:0]  dp8;
    logic [7:0]  blk8;
    logic        cur_lz;
    logic [7:0]  onehot;
    logic        lz_hit;
    logic [N_DIG-1:0] sel_log;
    logic [6:0]  seg_log;
    logic        dp_log;

    always_comb begin
        start_st   = (BLANK_CYC == 0) ? S_DRIVE : S_GUARD;
        slot_start = (state_q != S_OFF) && (cnt_q == '0);
        slot_last  = (cnt_q == CW'(SCAN_CYC - 1));

        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        unique case (state_q)
            S_OFF: begin
                state_d = start_st;
                cnt_d   = '0;
                slot_d  = '0;
            end
            S_GUARD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(BL1)) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (slot_last) begin
                    cnt_d   = '0;
                    state_d = start_st;
                    slot_d  = (slot_q == 3'(N_DIG - 1)) ? 3'd0 : slot_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase
        if (!io.enable) begin
            state_d = S_OFF;
            cnt_d   = '0;
            slot_d  = '0;
        end

        // blink timebase is free-running, independent of enable
        if (bcnt_q == BW'(BLINK_CYC - 1)) begin
            bcnt_d = '0;
            bph_d  = ~bph_q;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
            bph_d  = bph_q;
        end

        // first slot cycle uses live inputs so a zero-length guard still works
        sdig_d = slot_start ? io.digits   : sdig_q;
        sdp_d  = slot_start ? io.dp_en    : sdp_q;
        sblk_d = slot_start ? io.blink_en : sblk_q;
        slz_d  = slot_start ? io.lz_blank : slz_q;

        dig32 = '0;
        dig32[4*N_DIG-1:0] = sdig_d;
        dp8 = '0;
        dp8[N_DIG-1:0] = sdp_d;
        blk8 = '0;
        blk8[N_DIG-1:0] = sblk_d;
        cur_lz = slz_d;

        onehot = 8'd1 << slot_q;
        lz_hit = cur_lz && (slot_q != 3'd0) &&
                 ((dig32 >> {slot_q, 2'b00}) == 32'd0);

        sel_log = '0;
        seg_log = '0;
        dp_log  = 1'b0;
        tick_d  = 1'b0;
        if (state_q == S_DRIVE && io.enable) begin
            sel_log = onehot[N_DIG-1:0];
            if (!(bph_q && blk8[slot_q])) begin
                seg_log = lz_hit ? 7'h00 : dec7(dig32[{slot_q, 2'b00} +: 4]);
                dp_log  = dp8[slot_q];
            end
            tick_d = slot_last && (slot_q == 3'(N_DIG - 1));
        end
        sel_d  = SEL_ACT_LOW ? ~sel_log : sel_log;
        ment_d = SEG_ACT_LOW ? ~seg_log : seg_log;
        dp_d   = SEG_ACT_LOW ? ~dp_log  : dp_log;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            slot_q  <= '0;
            bcnt_q  <= '0;
            bph_q   <= 1'b0;
            sdig_q  <= '0;
            sdp_q   <= '0;
            sblk_q  <= '0;
            slz_q   <= 1'b0;
            sel_q   <= SEL_OFF;
            ment_q  <= SEG_OFF;
            dp_q    <= DP_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            bcnt_q  <= bcnt_d;
            bph_q   <= bph_d;
            sdig_q  <= sdig_d;
            sdp_q   <= sdp_d;
            sblk_q  <= sblk_d;
            slz_q   <= slz_d;
            sel_q   <= sel_d;
            ment_q  <= ment_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign io.seg_sel    = sel_q;
    assign io.seg_ment   = ment_q;
    assign io.seg_dp     = dp_q;
    assign io.slot_idx   = slot_q;
    assign io.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_multi.sv
// Bench for seg_scan_multi: scan-position reference model checked every cycle,
// directed literal checks, then randomized content/enable/reset traffic.
module tb_seg_scan_multi;
    localparam int N     = 4;
    localparam int SCAN  = 8;
    localparam int BLANK = 2;
    localparam int BLINK = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_multi_if #(.N_DIG(N)) io ();

    seg_scan_multi #(
        .N_DIG(N), .SCAN_CYC(SCAN), .BLANK_CYC(BLANK),
        .BLINK_CYC(BLINK), .SEL_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(io.slave)
    );

    int errs = 0;
    int checks = 0;

    // reference model: position p counts cycles since the run started
    logic [6:0] seg_tbl [16];
    int p = -1;
    int bcount = 0;
    bit mvalid = 1'b0;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_blk;
    logic        m_lz;
    logic [3:0]  e_sel;
    logic [6:0]  e_ment;
    logic        e_dp;
    logic [2:0]  e_slot;
    logic        e_tick;

    initial begin
        seg_tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                    7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    end

    always @(posedge clk) begin
        int ph, cnt, sl;
        bit lit, zeros;
        logic [3:0] d;
        logic [6:0] seg;
        logic dp;
        e_sel = 4'hF; e_ment = 7'h7F; e_dp = 1'b1; e_slot = 3'd0; e_tick = 1'b0;
        if (rst) begin
            p = -1; bcount = 0; mvalid = 1'b1;
        end else begin
            ph = (bcount / BLINK) % 2;
            bcount++;
            if (!io.enable) begin
                p = -1;
            end else if (p < 0) begin
                p = 0;
            end else begin
                cnt = p % SCAN;
                sl  = (p / SCAN) % N;
                if (cnt == 0) begin
                    m_dig = io.digits; m_dp = io.dp_en;
                    m_blk = io.blink_en; m_lz = io.lz_blank;
                end
                if (cnt >= BLANK) begin
                    zeros = 1'b1;
                    for (int j = sl; j < N; j++)
                        if (m_dig[4*j +: 4] != 4'd0) zeros = 1'b0;
                    lit = !(ph == 1 && m_blk[sl]);
                    d = m_dig[4*sl +: 4];
                    seg = (!lit || (m_lz && sl >= 1 && zeros)) ? 7'h00 : seg_tbl[d];
                    dp  = lit && m_dp[sl];
                    e_sel  = ~(4'b0001 << sl);
                    e_ment = ~seg;
                    e_dp   = ~dp;
                end
                e_slot = 3'(((p + 1) / SCAN) % N);
                e_tick = ((p + 1) % (SCAN * N)) == 0;
                p++;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if (io.seg_sel !== e_sel || io.seg_ment !== e_ment ||
                io.seg_dp !== e_dp || io.slot_idx !== e_slot ||
                io.frame_tick !== e_tick) begin
                errs++;
                $display("FAIL model t=%0t got sel=%h seg=%h dp=%b slot=%0d tick=%b want sel=%h seg=%h dp=%b slot=%0d tick=%b",
                         $time, io.seg_sel, io.seg_ment, io.seg_dp, io.slot_idx,
                         io.frame_tick, e_sel, e_ment, e_dp, e_slot, e_tick);
            end
        end
    end

    task automatic lit_chk(input string nm, input logic [3:0] sel,
                           input logic [6:0] ment, input logic dp);
        checks++;
        if (io.seg_sel !== sel || io.seg_ment !== ment || io.seg_dp !== dp) begin
            errs++;
            $display("FAIL %s got sel=%h seg=%h dp=%b want sel=%h seg=%h dp=%b",
                     nm, io.seg_sel, io.seg_ment, io.seg_dp, sel, ment, dp);
        end
    endtask

    task automatic int_chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (io.frame_tick !== 1'b1 && n < 300);
        if (io.frame_tick !== 1'b1) begin
            errs++;
            checks++;
            $display("FAIL tick_timeout got=0 want=1 after %0d cycles", n);
        end
    endtask

    // starting at a frame tick, check each slot's first lit output
    task automatic frame_chk(input string nm, input logic [6:0] m0,
                             input logic [6:0] m1, input logic [6:0] m2,
                             input logic [6:0] m3);
        step(3);  lit_chk({nm, "_d0"}, 4'hE, m0, 1'b1);
        step(8);  lit_chk({nm, "_d1"}, 4'hD, m1, 1'b1);
        step(8);  lit_chk({nm, "_d2"}, 4'hB, m2, 1'b1);
        step(8);  lit_chk({nm, "_d3"}, 4'h7, m3, 1'b1);
    endtask

    initial begin
        int n, nlit, ndark, r;
        io.enable = 1'b1; io.digits = 16'h1234; io.dp_en = '0;
        io.blink_en = '0; io.lz_blank = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit_chk("reset", 4'hF, 7'h7F, 1'b1);
            int_chk("reset_slot", int'(io.slot_idx), 0);
        end
        rst = 1'b0;

        wait_tick(n);
        wait_tick(n);
        int_chk("frame_period", n, 32);
        lit_chk("tick_last_slot", 4'h7, 7'h4F, 1'b1);
        step(1); lit_chk("guard0", 4'hF, 7'h7F, 1'b1);
        step(2); lit_chk("scan_d0", 4'hE, 7'h4C, 1'b1);
        step(8); lit_chk("scan_d1", 4'hD, 7'h06, 1'b1);
        step(8); lit_chk("scan_d2", 4'hB, 7'h12, 1'b1);

        io.digits = 16'h0050; io.lz_blank = 1'b1;
        wait_tick(n); wait_tick(n);
        frame_chk("lz0050", 7'h01, 7'h24, 7'h7F, 7'h7F);
        io.digits = 16'hA0A0; io.lz_blank = 1'b0;
        wait_tick(n); wait_tick(n);
        frame_chk("codeA", 7'h01, 7'h7F, 7'h01, 7'h7F);
        io.digits = 16'h0000; io.lz_blank = 1'b1;
        wait_tick(n); wait_tick(n);
        frame_chk("lz0000", 7'h01, 7'h7F, 7'h7F, 7'h7F);

        io.digits = 16'h1234; io.lz_blank = 1'b0;
        io.blink_en = 4'b0001; io.dp_en = 4'b0001;
        wait_tick(n); wait_tick(n);
        nlit = 0; ndark = 0;
        for (int f = 0; f < 8; f++) begin
            step(3);
            int_chk("blink_sel", int'(io.seg_sel), 14);
            if (io.seg_ment === 7'h4C && io.seg_dp === 1'b0) nlit++;
            else if (io.seg_ment === 7'h7F && io.seg_dp === 1'b1) ndark++;
            wait_tick(n);
        end
        int_chk("blink_lit_frames", nlit, 4);
        int_chk("blink_dark_frames", ndark, 4);

        io.blink_en = '0; io.dp_en = '0;
        wait_tick(n); wait_tick(n);
        step(4); io.digits = 16'h5678;
        step(3); lit_chk("snap_hold", 4'hE, 7'h4C, 1'b1);
        step(4); lit_chk("snap_next", 4'hD, 7'h0F, 1'b1);
        step(9); io.enable = 1'b0;
        step(1); lit_chk("disable_dark", 4'hF, 7'h7F, 1'b1);
        int_chk("disable_slot", int'(io.slot_idx), 0);
        step(2); io.enable = 1'b1;
        wait_tick(n);
        int_chk("reenable_first_tick", n, 33);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = int'($urandom_range(999));
            rst = (r == 999);
            if (r < 25) begin
                for (int j = 0; j < N; j++)
                    io.digits[4*j +: 4] = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
                io.dp_en = 4'($urandom);
                io.blink_en = 4'($urandom);
                io.lz_blank = 1'($urandom);
            end
            if (io.enable && r >= 990 && r < 996) io.enable = 1'b0;
            else if (!io.enable && r < 150) io.enable = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
